// File: rtl/gray_seq_pkg.sv
// ---------------------------------------------------------------------------
// gray_seq_pkg
// Shared types and helpers for the gray code sequencing controller.
//   state_t   : controller states (IDLE, RUN)
//   FLIP_W    : width of the flip-index field for an N-bit gray word
//   tz_index  : trailing-zero index of a step count, N-1 when the count is 0
// ---------------------------------------------------------------------------
package gray_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width needed to name any bit of an N-bit word.
    function automatic int FLIP_W(input int n);
        return $clog2(n);
    endfunction

    // Ruler-sequence bit for a step count. Only the low n bits of v count.
    // A zero count means a full wrap, which flips the top bit.
    function automatic int tz_index(input logic [15:0] v, input int n);
        int r;
        r = n - 1;
        for (int i = 15; i >= 0; i--) begin
            if ((i < n) && v[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gray_ruler_step.sv
// ---------------------------------------------------------------------------
// gray_ruler_step
// Holds the step count and the current gray word, and advances the word by
// one ruler step when enabled. Build option GRAY_SEQ_CTRL_DIR_EN adds the
// 'down' input for reverse stepping.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : return count, word and flip index to zero (wins over step)
//   step       : apply one step
//   down       : (GRAY_SEQ_CTRL_DIR_EN only) 1 = step downwards
//   code       : current gray word
//   flip       : index of the bit changed by the last step
// ---------------------------------------------------------------------------
module gray_ruler_step
    import gray_seq_pkg::*;
#(
    parameter int N = 3,
    localparam int FW = FLIP_W(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          step,
`ifdef GRAY_SEQ_CTRL_DIR_EN
    input  logic          down,
`endif
    output logic [N-1:0]  code,
    output logic [FW-1:0] flip
);

    logic [N-1:0]  cnt;
    logic [N-1:0]  cnt_nxt;
    logic [FW-1:0] f_nxt;

    // Next count and the bit to flip. Going up, the bit is the trailing-zero
    // index of the new count; going down it is that of the old count, which
    // retraces the up sequence in reverse.
    always_comb begin
        cnt_nxt = cnt + N'(1);
        f_nxt   = FW'(tz_index(16'(cnt_nxt), N));
`ifdef GRAY_SEQ_CTRL_DIR_EN
        if (down) begin
            cnt_nxt = cnt - N'(1);
            f_nxt   = FW'(tz_index(16'(cnt), N));
        end
`endif
    end

    // Count, word and flip index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            code <= '0;
            flip <= '0;
        end else if (clear) begin
            cnt  <= '0;
            code <= '0;
            flip <= '0;
        end else if (step) begin
            cnt  <= cnt_nxt;
            code <= code ^ (N'(1) << f_nxt);
            flip <= f_nxt;
        end
    end

endmodule

// File: rtl/gray_seq_ctrl.sv
// ---------------------------------------------------------------------------
// gray_seq_ctrl
// Streams an N-bit reflected gray sequence on a valid/ready interface, with
// start/stop control, single-pass or continuous wrap, last and done framing.
// Build option GRAY_SEQ_CTRL_DIR_EN adds the 'dir' input (0 up, 1 down).
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : begin a sequence (IDLE only, ignored while stop is high)
//   stop       : abort and return to IDLE after any same-cycle transfer
//   cont       : latched at start; 1 = continuous wrap, 0 = one pass
//   dir        : (GRAY_SEQ_CTRL_DIR_EN only) latched at start
//   out_ready  : sink accepts the word
//   out_valid  : out_code/out_flip/out_last are valid
//   out_code   : current gray word
//   out_flip   : bit changed from the previous word (0 on the first word)
//   out_last   : word is the 2^N-th of the current pass
//   busy       : high in RUN
//   done       : one-cycle pulse on return to IDLE
// ---------------------------------------------------------------------------
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int N = 3,
    localparam int FW = FLIP_W(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          cont,
`ifdef GRAY_SEQ_CTRL_DIR_EN
    input  logic          dir,
`endif
    input  logic          out_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_code,
    output logic [FW-1:0] out_flip,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    state_t        state;
    state_t        next_state;
    logic [N-1:0]  idx;
    logic          last_q;
    logic          cont_q;
    logic          done_q;
    logic          xfer;
    logic          start_ok;
    logic          end_run;
    logic [N-1:0]  code_q;
    logic [FW-1:0] flip_q;
`ifdef GRAY_SEQ_CTRL_DIR_EN
    logic          dir_q;
`endif

    // Handshake and control events seen this cycle.
    always_comb begin
        xfer     = (state == RUN) && out_ready;
        start_ok = (state == IDLE) && start && !stop;
        end_run  = (state == RUN) && (stop || (xfer && last_q && !cont_q));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ok) next_state = RUN;
            RUN:     if (end_run)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Beat index, registered last flag, latched mode bits and done pulse.
    // last_q is computed from the index the word will have after the step,
    // so out_last is a plain flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            last_q <= 1'b0;
            cont_q <= 1'b0;
            done_q <= 1'b0;
`ifdef GRAY_SEQ_CTRL_DIR_EN
            dir_q  <= 1'b0;
`endif
        end else begin
            done_q <= end_run;
            if (start_ok) begin
                idx    <= '0;
                last_q <= 1'b0;
                cont_q <= cont;
`ifdef GRAY_SEQ_CTRL_DIR_EN
                dir_q  <= dir;
`endif
            end else if (end_run) begin
                idx    <= '0;
                last_q <= 1'b0;
            end else if (xfer) begin
                idx    <= idx + N'(1);
                last_q <= ((idx + N'(1)) == '1);
            end
        end
    end

    // Word generator: cleared on entry to and exit from RUN, stepped on each
    // transfer that keeps the sequence running.
    gray_ruler_step #(.N(N)) u_step (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_ok || end_run),
        .step  (xfer && !end_run),
`ifdef GRAY_SEQ_CTRL_DIR_EN
        .down  (dir_q),
`endif
        .code  (code_q),
        .flip  (flip_q)
    );

    // Output decode; every output comes straight from a register.
    always_comb begin
        out_valid = (state == RUN);
        busy      = (state == RUN);
        out_code  = code_q;
        out_flip  = flip_q;
        out_last  = last_q;
        done      = done_q;
    end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gray_seq_ctrl
// Scoreboard bench for gray_seq_ctrl with N=3. Stimulus pushes the expected
// words into a queue; a monitor pops and compares on every transfer.
// Build option GRAY_SEQ_CTRL_DIR_EN enables the down-direction scenario.
// ---------------------------------------------------------------------------
module tb_gray_seq_ctrl;

    typedef struct packed {
        logic [2:0] code;
        logic [1:0] flip;
        logic       last;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       cont;
`ifdef GRAY_SEQ_CTRL_DIR_EN
    logic       dir;
`endif
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_code;
    logic [1:0] out_flip;
    logic       out_last;
    logic       busy;
    logic       done;

    int   checks;
    int   failures;
    exp_t sb_q[$];

    // Hand-computed sequences; entry 0 of the flip table is the wrap flip.
    int up_code[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    int up_flip[8] = '{2, 0, 1, 0, 2, 0, 1, 0};
    int dn_code[8] = '{0, 4, 5, 7, 6, 2, 3, 1};
    int dn_flip[8] = '{0, 2, 0, 1, 0, 2, 0, 1};

    gray_seq_ctrl #(.N(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
`ifdef GRAY_SEQ_CTRL_DIR_EN
        .dir       (dir),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_flip  (out_flip),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic c,
                                 input logic r);
        start     = s;
        stop      = p;
        cont      = c;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushPass(input int n_words, input bit down);
        for (int k = 0; k < n_words; k++) begin
            int   pos;
            exp_t e;
            pos    = k % 8;
            e.code = down ? 3'(dn_code[pos]) : 3'(up_code[pos]);
            e.flip = (k == 0) ? 2'd0 : (down ? 2'(dn_flip[pos]) : 2'(up_flip[pos]));
            e.last = (pos == 7);
            sb_q.push_back(e);
        end
    endtask

    // Monitor: one expected word consumed per transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_word actual=%0h expected=none", out_code);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("word_code", 32'(out_code), 32'(e.code));
                checkOutput("word_flip", 32'(out_flip), 32'(e.flip));
                checkOutput("word_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
`ifdef GRAY_SEQ_CTRL_DIR_EN
        dir      = 1'b0;
`endif
        applyStimulus(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_code",  32'(out_code),  0);
        checkOutput("rst_flip",  32'(out_flip),  0);
        checkOutput("rst_last",  32'(out_last),  0);
        checkOutput("rst_busy",  32'(busy),      0);
        checkOutput("rst_done",  32'(done),      0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_valid", 32'(out_valid), 0);

        $display("[TB] single pass");
        pushPass(8, 0);
        applyStimulus(1, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        checkOutput("sp_first_valid", 32'(out_valid), 1);
        checkOutput("sp_first_busy",  32'(busy),      1);
        checkOutput("sp_first_code",  32'(out_code),  0);
        repeat (7) tick();
        checkOutput("sp_word8_last", 32'(out_last), 1);
        tick();
        checkOutput("sp_end_valid", 32'(out_valid), 0);
        checkOutput("sp_end_done",  32'(done),      1);
        checkOutput("sp_end_busy",  32'(busy),      0);
        checkOutput("sp_end_code",  32'(out_code),  0);
        tick();
        checkOutput("sp_done_drop", 32'(done), 0);

        $display("[TB] backpressure");
        pushPass(8, 0);
        applyStimulus(1, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        repeat (3) tick();
        checkOutput("bp_word4", 32'(out_code), 2);
        applyStimulus(0, 0, 0, 0);
        repeat (3) begin
            tick();
            checkOutput("bp_hold_valid", 32'(out_valid), 1);
            checkOutput("bp_hold_code",  32'(out_code),  2);
        end
        applyStimulus(0, 0, 0, 1);
        repeat (4) tick();
        checkOutput("bp_word8_last", 32'(out_last), 1);
        tick();
        checkOutput("bp_end_done", 32'(done), 1);

        $display("[TB] continuous, started in the done cycle");
        pushPass(20, 0);
        applyStimulus(1, 0, 1, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        checkOutput("ct_first_valid", 32'(out_valid), 1);
        checkOutput("ct_first_code",  32'(out_code),  0);
        repeat (20) begin
            checkOutput("ct_busy", 32'(busy), 1);
            checkOutput("ct_done", 32'(done), 0);
            tick();
        end
        applyStimulus(0, 1, 0, 0);
        tick();
        checkOutput("ct_stop_valid", 32'(out_valid), 0);
        checkOutput("ct_stop_done",  32'(done),      1);
        applyStimulus(0, 0, 0, 0);
        tick();

        $display("[TB] stop");
        pushPass(5, 0);
        applyStimulus(1, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        repeat (4) tick();
        checkOutput("st_word5", 32'(out_code), 6);
        applyStimulus(0, 1, 0, 1);
        tick();
        checkOutput("st_valid", 32'(out_valid), 0);
        checkOutput("st_done",  32'(done),      1);
        checkOutput("st_code",  32'(out_code),  0);
        checkOutput("st_flip",  32'(out_flip),  0);
        checkOutput("st_busy",  32'(busy),      0);
        applyStimulus(1, 1, 0, 1);
        tick();
        checkOutput("st_start_blocked", 32'(out_valid), 0);
        applyStimulus(0, 0, 0, 0);
        tick();

`ifdef GRAY_SEQ_CTRL_DIR_EN
        $display("[TB] down direction");
        pushPass(8, 1);
        dir = 1'b1;
        applyStimulus(1, 0, 0, 1);
        tick();
        dir = 1'b0;
        applyStimulus(0, 0, 0, 1);
        repeat (8) tick();
        checkOutput("dn_end_done", 32'(done), 1);
        applyStimulus(0, 0, 0, 0);
        tick();
`endif

        $display("[TB] reset mid-run");
        pushPass(2, 0);
        applyStimulus(1, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        repeat (2) tick();
        applyStimulus(0, 0, 0, 0);
        checkOutput("rm_word3", 32'(out_code), 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rm_valid", 32'(out_valid), 0);
        checkOutput("rm_code",  32'(out_code),  0);
        checkOutput("rm_busy",  32'(busy),      0);
        checkOutput("rm_flip",  32'(out_flip),  0);
        tick();
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 1);
        repeat (3) begin
            tick();
            checkOutput("rm_idle_valid", 32'(out_valid), 0);
        end
        pushPass(8, 0);
        applyStimulus(1, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 1);
        checkOutput("rm_restart_code", 32'(out_code), 0);
        repeat (8) tick();
        checkOutput("rm_restart_done", 32'(done), 1);
        applyStimulus(0, 0, 0, 0);
        tick();

        checkOutput("scoreboard_empty", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_seq_ctrl.md
# gray_seq_ctrl

Sequencing controller for the n-bit gray code datapath. Steps an N-bit reflected gray sequence one word per accepted beat, stepping by flipping the ruler-sequence bit (trailing-zero index of the step count) rather than by binary-to-gray conversion. Words go out on a valid/ready stream with start/stop control, single-pass or continuous wrap, and last/done framing. It replaces free-running, unreset sequence emission with a controllable stream that downstream consumers can stall.

## Interface
Parameters:
- N, default 3, gray word width in bits. Legal range is 2 to 16.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sequence. Honoured only in IDLE.
- stop  in  1  abort the sequence and return to IDLE.
- cont  in  1  sampled at an accepted start. 1 selects continuous wrap; 0 selects a single pass of 2^N words.
- out_ready  in  1  sink accepts the word.
- out_valid  out  1  out_code, out_flip and out_last are valid.
- out_code  out  N  current gray word.
- out_flip  out  $clog2(N)  index of the bit that differs from the previous word. It is 0 on the first word.
- out_last  out  1  word is the 2^N-th word of the current pass.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on return to IDLE.

## Operation
- States are IDLE and RUN.
- A beat transfers on a rising edge when out_valid and out_ready are both high.
- **IDLE:**
  - out_valid, out_code, out_flip, out_last and busy are 0.
  - start=1 with stop=0: go to RUN.
    - Step counter cnt is cleared to 0.
    - Beat index idx is cleared to 0.
    - out_code is set to 0 and out_flip to 0.
    - cont is latched.
  - stop has no effect, and start is ignored while stop=1.
- **RUN:**
  - out_valid=1 and busy=1.
  - out_code, out_flip and out_last hold stable until the beat transfers.
  - On transfer in the up direction:
    - cnt is incremented modulo 2^N.
    - f = trailing-zero index of the new cnt. When the new cnt is 0, f = N-1.
    - out_code bit f is inverted and out_flip is set to f.
    - idx is incremented modulo 2^N.
  - out_last = (idx == 2^N-1).
  - On a transfer with out_last=1:
    - cont=0: go to IDLE and pulse done.
    - cont=1: continue. The next word is gray(0) with flip N-1.
  - stop=1 in RUN:
    - Any same-cycle transfer completes.
    - Then go to IDLE and pulse done.
  - start in RUN is ignored.
- On every return to IDLE, the out_* signals clear to 0.
- Arithmetic rules:
  - cnt and idx are N bits and wrap silently.
  - out_flip is always < N.

## Timing
- Reset values: all outputs are 0 and the state is IDLE. Asynchronous assertion mid-run clears immediately. No beat completes on the reset edge.
- start is high at edge t. At t+1: out_valid=1, out_code=0, busy=1.
- Throughput is one word per cycle while out_ready stays high. There are no bubbles, including across a continuous-mode wrap.
- After the final single-pass transfer (or a stop) at edge t, at t+1: out_valid=0, busy=0, done=1. At t+2: done=0.
- All outputs are registered. There is no combinational path from out_ready to out_valid.
- A start arriving in the done cycle is accepted. This permits back-to-back passes with a one-cycle gap.

## Configuration
- Macro: GRAY_SEQ_CTRL_DIR_EN.
- **Defined:**
  - Adds input port dir (1 bit), latched at an accepted start. 0 = up, 1 = down.
  - In down mode, cnt decrements modulo 2^N and f = trailing-zero index of the old cnt (N-1 when the old cnt is 0).
  - The first word is still 0.
  - idx and out_last behave identically in both directions.
- **Undefined:** there is no dir port and the direction is up only. The down-mode logic is not synthesised.

## Structure
- Package gray_seq_pkg holds:
  - the state enum typedef (IDLE, RUN);
  - the function computing the trailing-zero index with the N-1 fallback for zero;
  - the width localparam helper FLIP_W(N) = $clog2(N).
- Sub-module gray_ruler_step is registered. It holds cnt and out_code and applies one step on an enable, with direction when the macro is defined. The top level keeps the FSM, idx, the handshake and done.

## Test plan
All scenarios use N=3.
- **Single pass.** Stimulus: start with cont=0, out_ready=1. Required response:
  - out_code is 000,001,011,010,110,111,101,100 on 8 consecutive cycles.
  - out_flip is 0,0,1,0,2,0,1,0.
  - out_last is high on word 8 only.
  - done pulses on the next cycle.
- **Backpressure.** Stimulus: out_ready=0 for 3 cycles while word 4 (010) is presented. Required response: 010 is held with out_valid=1 and no word is skipped or duplicated. It resumes 110,111,...
- **Continuous.** Stimulus: cont=1, 20 beats. Required response:
  - word 9 = 000 with out_flip=2;
  - out_last is high on beats 8 and 16;
  - done never pulses and busy stays high.
- **Stop.** Stimulus: stop=1 with out_ready=1 while word 5 (110) is presented. Required response: 110 transfers; the next cycle has out_valid=0, done=1, out_code=000.
- **Down direction** (macro defined). Stimulus: dir=1. Required response: out_code is 000,100,101,111,110,010,011,001 and out_flip is 0,2,0,1,0,2,0,1.
- **Reset mid-run.** Stimulus: rst_n low at word 3. Required response:
  - All outputs are 0 immediately.
  - After release, out_valid stays 0 until a new start is given.
  - The restarted sequence begins at 000.
